uart_rx: RTL

Asynchronous UART receiver, 8N1, LSB first. It sits at the serial input pin and turns the incoming line into byte-wide words with a one-cycle valid strobe. Sampling is driven by an internal oversampled baud tick; the stop bit is checked and bad frames are flagged. It is the receive-side counterpart to the UART transmit path and shares that path's baud configuration.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_baud_tick_gen.sv | 43 ++++
 rtl/uart_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions used by the receive path and its baud tick generator.
//   - rx_state_t : receiver FSM states
//   - DATA_BITS  : payload bits per frame (8N1)
//   - log2       : ceiling log2 for sizing counters from parameters
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Ceiling log2; log2(1) = 0. Only ever evaluated on constants.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// Free-running tick generator producing a one-clk pulse at baud*oversampling.
// Ports:
//   clk    in  1 : system clock
//   enable in  1 : tick enable (held high by the receiver)
//   tick   out 1 : one-clk strobe at the oversampled baud rate
// The divider has no reset on purpose: its phase relative to an incoming
// frame is arbitrary anyway and the receiver tolerates one tick of
// start-edge uncertainty.
module baud_tick_gen
    import uart_rx_pkg::*;
#(
    parameter int clk_freq     = 12000000,
    parameter int baud         = 115200,
    parameter int oversampling = 8
) (
    input  logic clk,
    input  logic enable,
    output logic tick
);

    localparam int TICK_RATE = baud * oversampling;
    // Round to nearest divisor so the residual rate error stays small.
    localparam int DIV_RAW   = (clk_freq + TICK_RATE / 2) / TICK_RATE;
    localparam int DIV       = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int DW        = log2(DIV);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (enable) begin
            if (div_cnt == DW'(DIV - 1)) begin
                div_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled by an internal baud tick.
// Ports:
//   clk        in  1 : system clock, rising edge
//   rst        in  1 : asynchronous active-high reset
//   rxd        in  1 : serial line, idle high, asynchronous to clk
//   data       out 8 : last good byte received
//   data_valid out 1 : one-clk strobe, data holds a new good byte
//   frame_err  out 1 : one-clk strobe, stop bit sampled low
//   busy       out 1 : high whenever the FSM is not idle
// Start bit is confirmed at its middle, then every data/stop bit is sampled
// one full bit period later. A low stop bit parks the FSM in BREAK until the
// line goes high again so a stuck-low line cannot retrigger frames.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int clk_freq     = 12000000,
    parameter int baud         = 115200,
    parameter int oversampling = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int            CW   = log2(oversampling) + 1;
    localparam logic [CW-1:0] HALF = CW'(oversampling / 2);
    localparam logic [CW-1:0] FULL = CW'(oversampling);

    logic                 tick;
    logic                 rx_meta;
    logic                 rxs;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_inc;
    logic [2:0]           bitn;
    logic [DATA_BITS-1:0] sr;

    baud_tick_gen #(
        .clk_freq     (clk_freq),
        .baud         (baud),
        .oversampling (oversampling)
    ) u_tick (
        .clk    (clk),
        .enable (1'b1),
        .tick   (tick)
    );

    // Two-flop synchronizer; reset to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // Thresholds are compared against the post-increment count so that the
    // decision lands on the tick that would make cnt reach HALF/FULL.
    assign cnt_inc = cnt + 1'b1;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bitn       <= '0;
            sr         <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rxs) begin
                            state <= ST_START;
                            cnt   <= CW'(1);
                        end
                    end
                    ST_START: begin
                        if (cnt_inc == HALF) begin
                            cnt <= '0;
                            if (rxs) begin
                                state <= ST_IDLE;   // too short: glitch
                            end else begin
                                state <= ST_DATA;
                                bitn  <= '0;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_inc == FULL) begin
                            sr   <= {rxs, sr[DATA_BITS-1:1]};
                            cnt  <= '0;
                            bitn <= bitn + 3'd1;
                            if (bitn == 3'd7) state <= ST_STOP;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_STOP: begin
                        if (cnt_inc == FULL) begin
                            cnt <= '0;
                            if (rxs) begin
                                data       <= sr;
                                data_valid <= 1'b1;
                                state      <= ST_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_BREAK;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_BREAK: begin
                        if (rxs) state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
